// File: rtl/combination_lock_fsm_param.sv
// Parametrised rotary combination lock: N alternating-direction digits, Center at a final code, lockout after repeated failures.
// Optional auto-relock from OPEN is enabled by defining COMBO_LOCK_AUTO_RELOCK_EN.
module combination_lock_fsm_param #(
  parameter int                                NUM_DIGITS     = 2,
  parameter int                                COUNT_WIDTH    = 5,
  parameter logic [NUM_DIGITS*COUNT_WIDTH-1:0] COMBO          = {5'd7, 5'd13},
  parameter int                                FINAL_CODE     = 17,
  parameter int                                MAX_FAILS      = 3,
  parameter int                                LOCKOUT_CYCLES = 64,
  parameter int                                RELOCK_CYCLES  = 256
) (
  input  logic                   Clk,
  input  logic                   South,
  input  logic                   Right,
  input  logic                   Left,
  input  logic [COUNT_WIDTH-1:0] Count,
  input  logic                   Center,
  output logic [2:0]             state,
  output logic                   Locked,
  output logic                   Lockout,
  output logic [2:0]             digit_idx,
  output logic [3:0]             fail_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    ARMED   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || MAX_FAILS < 1 || MAX_FAILS > 15 ||
      LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1) begin : g_bad_params
    $error("combination_lock_fsm_param: parameter out of range");
  end

  // Timers load N-1 on entry and leave when they read zero, giving exactly N cycles in the state.
  localparam int             LW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0]  LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
  localparam int             RW          = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RW-1:0]  RELOCK_LOAD = RW'(RELOCK_CYCLES - 1);
  logic [RW-1:0]             relock_q, relock_d;
`endif

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    fails_q, fails_d;
  logic [LW-1:0] lock_tmr_q, lock_tmr_d;

  logic right_only, left_only, any_dir, req_dir, opp_dir;
  logic digit_hit, last_digit, fail_hit;

  assign right_only = Right & ~Left;
  assign left_only  = Left & ~Right;
  assign any_dir    = right_only | left_only;
  assign req_dir    = idx_q[0] ? right_only : left_only;
  assign opp_dir    = idx_q[0] ? left_only : right_only;
  assign last_digit = (idx_q == 3'(NUM_DIGITS - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    digit_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i) && Count == COMBO[i*COUNT_WIDTH +: COUNT_WIDTH]) digit_hit = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fails_d    = fails_q;
    lock_tmr_d = lock_tmr_q;
    fail_hit   = 1'b0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
    relock_d   = relock_q;
`endif
    case (state_q)
      IDLE: begin
        if (right_only) begin
          state_d = ENTRY;
          idx_d   = 3'd0;
        end
      end
      ENTRY: begin
        if (req_dir && digit_hit) begin
          if (last_digit) begin
            state_d = ARMED;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (opp_dir) begin
          fail_hit = 1'b1;
        end
      end
      ARMED: begin
        if (Center) begin
          if (Count == COUNT_WIDTH'(FINAL_CODE)) begin
            state_d = OPEN;
            fails_d = 4'd0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
            relock_d = RELOCK_LOAD;
`endif
          end else begin
            fail_hit = 1'b1;
          end
        end
      end
      OPEN: begin
        if (any_dir) begin
          state_d = IDLE;
        end
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
        else if (relock_q == '0) begin
          state_d = IDLE;
        end else begin
          relock_d = relock_q - 1'b1;
        end
`endif
      end
      LOCKOUT: begin
        if (lock_tmr_q == '0) begin
          state_d = IDLE;
          fails_d = 4'd0;
        end else begin
          lock_tmr_d = lock_tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase

    if (fail_hit) begin
      idx_d = 3'd0;
      if (fails_q + 4'd1 == 4'(MAX_FAILS)) begin
        state_d    = LOCKOUT;
        lock_tmr_d = LOCK_LOAD;
      end else begin
        state_d = IDLE;
        fails_d = (fails_q == 4'hF) ? fails_q : fails_q + 4'd1;
      end
    end
  end

  // NOTE: the reset branch is inside the clocked block, so South only acts on a rising Clk edge.
  always_ff @(posedge Clk) begin
    if (South) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      fails_q    <= 4'd0;
      lock_tmr_q <= '0;
      Locked     <= 1'b1;
      Lockout    <= 1'b0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
      relock_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates keep every register reading the pre-edge value of the others.
      state_q    <= state_d;
      idx_q      <= idx_d;
      fails_q    <= fails_d;
      lock_tmr_q <= lock_tmr_d;
      Locked     <= (state_d != OPEN);
      Lockout    <= (state_d == LOCKOUT);
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
      relock_q   <= relock_d;
`endif
    end
  end

  assign state      = state_q;
  assign digit_idx  = idx_q;
  assign fail_count = fails_q;

endmodule
